instruction_cache: RTL and testbench

- Page-based instruction buffer between DDR and the program counter.
- Fetches windows of ISA_DEPTH instructions from DDR into local RAM.
- Serves the instruction addressed by addr_ins to the AP controller.
- Reports its state and page count (load_times) back to the program counter, which stalls at a window boundary until the next page is loaded.

---
 rtl/ap_pkg.sv | 13 +
 rtl/ins_cache_ram.sv | 33 +++
 rtl/instruction_cache.sv | 138 +++++++++++++
 tb/tb_instruction_cache.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/ap_pkg.sv
// Definitions shared across the AP: instruction-cache state codes that the
// program counter compares against, and the DDR byte size of one instruction.
package ap_pkg;

  typedef enum logic [3:0] {
    START    = 4'd1,
    LOAD_INS = 4'd2,
    SENT_INS = 4'd3
  } ins_cache_state_e;

  localparam int INS_BYTES = 8;

endpackage

// File: rtl/ins_cache_ram.sv
// Simple dual-port page RAM: one write port plus one registered read port whose
// output holds its last value while no read is requested.
module ins_cache_ram #(
  parameter int DEPTH = 64,
  parameter int WIDTH = 64,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  input  logic [AW-1:0]    rd_addr,
  output logic [WIDTH-1:0] rd_data
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [WIDTH-1:0] rd_data_q;

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  // Output register is cleared on reset so the cache presents zero until the first read.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)       rd_data_q <= '0;
    else if (rd_en) rd_data_q <= mem[rd_addr];
  end

  assign rd_data = rd_data_q;

endmodule

// File: rtl/instruction_cache.sv
// Page-based instruction buffer: loads ISA_DEPTH-instruction windows from DDR and
// serves the instruction addressed by the program counter one cycle later.
module instruction_cache
  import ap_pkg::*;
#(
  parameter int ADDR_WIDTH_MEM  = 16,
  parameter int ISA_DEPTH       = 64,
  parameter int TOTAL_ISA_DEPTH = 128,
  parameter int DDR_ADDR_WIDTH  = 28,
  parameter int INS_WIDTH       = 64,
  parameter int ISA_BASE_ADDR   = 0
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [ADDR_WIDTH_MEM-1:0] addr_ins,
  output logic                      ins_cache_rdy,
  output logic [3:0]                st_cur_ins_cache,
  output logic [9:0]                load_times,
  output logic [INS_WIDTH-1:0]      ins_out,
  output logic                      ins_valid,
  output logic                      ddr_rd_en,
  output logic [DDR_ADDR_WIDTH-1:0] ddr_addr,
  input  logic                      ddr_rdy,
  input  logic [INS_WIDTH-1:0]      ddr_rd_data,
  input  logic                      ddr_rd_data_valid
);

  localparam int PAGE_SHIFT = $clog2(ISA_DEPTH);
  localparam int CNT_W      = PAGE_SHIFT + 1;

  ins_cache_state_e state_q, state_d;
  logic [9:0]       page_q, page_d;
  logic [9:0]       load_times_q, load_times_d;
  logic [CNT_W-1:0] req_cnt_q, req_cnt_d;
  logic [CNT_W-1:0] ret_cnt_q, ret_cnt_d;
  logic             ins_valid_q, ins_valid_d;

  logic [31:0] page_base, remaining, n_words, resident_base, addr_ext;
  logic        addr_jump, addr_in_prog, addr_in_page;
  logic        hit, miss, req_fire, ram_we, last_ret;

  // The last page may be shorter than ISA_DEPTH when the program length is not a multiple.
  always_comb begin
    page_base     = 32'(page_q) << PAGE_SHIFT;
    remaining     = 32'(TOTAL_ISA_DEPTH) - page_base;
    n_words       = (remaining < 32'(ISA_DEPTH)) ? remaining : 32'(ISA_DEPTH);
    resident_base = (32'(load_times_q) - 32'd1) << PAGE_SHIFT;
    addr_ext      = 32'(addr_ins);
    addr_jump     = addr_ins[ADDR_WIDTH_MEM-1];
    addr_in_prog  = addr_ext < 32'(TOTAL_ISA_DEPTH);
    addr_in_page  = (addr_ext >= resident_base) &&
                    (addr_ext < resident_base + 32'(ISA_DEPTH));
    hit           = (state_q == SENT_INS) && !addr_jump && addr_in_prog && addr_in_page;
    miss          = (state_q == SENT_INS) && !addr_jump && addr_in_prog && !addr_in_page;
  end

  assign ddr_rd_en = (state_q == LOAD_INS) && (32'(req_cnt_q) < n_words);
  assign req_fire  = ddr_rd_en && ddr_rdy;
  assign ram_we    = (state_q == LOAD_INS) && ddr_rd_data_valid;
  assign last_ret  = ram_we && (32'(ret_cnt_q) == n_words - 32'd1);
  assign ddr_addr  = (state_q == LOAD_INS) ?
                     DDR_ADDR_WIDTH'(32'(ISA_BASE_ADDR) +
                                     (page_base + 32'(req_cnt_q)) * 32'(INS_BYTES)) :
                     '0;

  always_comb begin
    state_d      = state_q;
    page_d       = page_q;
    load_times_d = load_times_q;
    req_cnt_d    = req_cnt_q;
    ret_cnt_d    = ret_cnt_q;
    ins_valid_d  = hit;
    case (state_q)
      START: begin
        page_d    = '0;
        req_cnt_d = '0;
        ret_cnt_d = '0;
        state_d   = LOAD_INS;
      end
      LOAD_INS: begin
        if (req_fire) req_cnt_d = req_cnt_q + CNT_W'(1);
        if (ram_we)   ret_cnt_d = ret_cnt_q + CNT_W'(1);
        if (last_ret) begin
          load_times_d = page_q + 10'd1;
          req_cnt_d    = '0;
          ret_cnt_d    = '0;
          state_d      = SENT_INS;
        end
      end
      SENT_INS: begin
        // Covers both the sequential window boundary and jumps into another page.
        if (miss) begin
          page_d  = 10'(addr_ext >> PAGE_SHIFT);
          state_d = LOAD_INS;
        end
      end
      default: state_d = START;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= START;
      page_q       <= '0;
      load_times_q <= '0;
      req_cnt_q    <= '0;
      ret_cnt_q    <= '0;
      ins_valid_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      page_q       <= page_d;
      load_times_q <= load_times_d;
      req_cnt_q    <= req_cnt_d;
      ret_cnt_q    <= ret_cnt_d;
      ins_valid_q  <= ins_valid_d;
    end
  end

  ins_cache_ram #(
    .DEPTH (ISA_DEPTH),
    .WIDTH (INS_WIDTH)
  ) u_ram (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (ram_we),
    .wr_addr (ret_cnt_q[PAGE_SHIFT-1:0]),
    .wr_data (ddr_rd_data),
    .rd_en   (hit),
    .rd_addr (addr_ins[PAGE_SHIFT-1:0]),
    .rd_data (ins_out)
  );

  assign ins_cache_rdy    = hit;
  assign st_cur_ins_cache = state_q;
  assign load_times       = load_times_q;
  assign ins_valid        = ins_valid_q;

endmodule

// File: tb/tb_instruction_cache.sv
// Scoreboard bench for instruction_cache: a DDR responder checks request addresses,
// and a monitor compares every ins_valid beat against queued expected instructions.
module tb_instruction_cache;
  import ap_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] addr_ins;
  logic        ins_cache_rdy;
  logic [3:0]  st_cur_ins_cache;
  logic [9:0]  load_times;
  logic [63:0] ins_out;
  logic        ins_valid;
  logic        ddr_rd_en;
  logic [27:0] ddr_addr;
  logic        ddr_rdy;
  logic [63:0] ddr_rd_data;
  logic        ddr_rd_data_valid;

  typedef struct packed {
    logic [63:0] data;
    int          due;
  } ret_t;

  int          checks = 0;
  int          errors = 0;
  logic [63:0] exp_ins [$];
  logic [27:0] exp_req [$];
  ret_t        ret_q [$];
  int          cyc = 0;
  int          last_due = 0;
  int          ret_count = 0;
  bit          bp_mode = 1'b0;
  bit          late_strobe = 1'b0;

  instruction_cache dut (
    .clk               (clk),
    .rst               (rst),
    .addr_ins          (addr_ins),
    .ins_cache_rdy     (ins_cache_rdy),
    .st_cur_ins_cache  (st_cur_ins_cache),
    .load_times        (load_times),
    .ins_out           (ins_out),
    .ins_valid         (ins_valid),
    .ddr_rd_en         (ddr_rd_en),
    .ddr_addr          (ddr_addr),
    .ddr_rdy           (ddr_rdy),
    .ddr_rd_data       (ddr_rd_data),
    .ddr_rd_data_valid (ddr_rd_data_valid)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: actual=0x%0h expected=0x%0h", name, actual, expected);
    end
  endtask

  // DDR responder: drives ready/return data on the falling edge and checks each accepted address.
  always @(negedge clk) begin
    int due;
    cyc++;
    ddr_rd_data_valid = 1'b0;
    if (!rst) begin
      ret_q.delete();
      last_due = 0;
    end
    if (late_strobe) begin
      ddr_rd_data_valid = 1'b1;
      ddr_rd_data       = 64'hDEAD_BEEF_0000_0000 | 64'(cyc);
    end else if (rst && ret_q.size() > 0 && ret_q[0].due <= cyc) begin
      ddr_rd_data_valid = 1'b1;
      ddr_rd_data       = ret_q[0].data;
      void'(ret_q.pop_front());
      ret_count++;
    end
    ddr_rdy = bp_mode ? ((cyc % 3) != 1) : 1'b1;
    if (rst && ddr_rd_en && ddr_rdy) begin
      if (exp_req.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL ddr_req: actual request at 0x%0h, expected no request", ddr_addr);
      end else begin
        checkOutput("ddr_req_addr", 64'(ddr_addr), 64'(exp_req.pop_front()));
      end
      due = cyc + 1;
      if (bp_mode && last_due + 1 + int'($urandom_range(0, 5)) > due)
        due = last_due + 1 + int'($urandom_range(0, 5));
      if (last_due + 1 > due) due = last_due + 1;
      ret_q.push_back('{data: 64'(ddr_addr >> 3), due: due});
      last_due = due;
    end
  end

  always @(negedge clk) begin
    if (rst && ins_valid) begin
      if (exp_ins.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL ins_out: actual valid beat 0x%0h, expected no beat", ins_out);
      end else begin
        checkOutput("ins_out", ins_out, exp_ins.pop_front());
      end
    end
  end

  task automatic applyStimulus(input logic [15:0] addr, input bit exp_hit,
                               input logic [63:0] exp_data);
    addr_ins = addr;
    #1;
    checkOutput($sformatf("rdy_addr_%0h", addr), 64'(ins_cache_rdy), 64'(exp_hit));
    if (exp_hit) exp_ins.push_back(exp_data);
    @(negedge clk);
  endtask

  task automatic waitState(input logic [3:0] st, input int max_cycles, input string name);
    int n = 0;
    while (st_cur_ins_cache !== st && n < max_cycles) begin
      @(negedge clk);
      n++;
    end
    checkOutput(name, 64'(st_cur_ins_cache), 64'(st));
  endtask

  task automatic pushPage(input int page);
    for (int i = 0; i < 64; i++) exp_req.push_back(28'((page * 64 + i) * 8));
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int n;
    rst               = 1'b0;
    addr_ins          = 16'h8000;
    ddr_rdy           = 1'b1;
    ddr_rd_data       = '0;
    ddr_rd_data_valid = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    checkOutput("rst_state", 64'(st_cur_ins_cache), 64'd1);
    checkOutput("rst_load_times", 64'(load_times), 64'd0);
    checkOutput("rst_rdy", 64'(ins_cache_rdy), 64'd0);
    checkOutput("rst_ins_valid", 64'(ins_valid), 64'd0);
    checkOutput("rst_ins_out", ins_out, 64'd0);
    checkOutput("rst_ddr_rd_en", 64'(ddr_rd_en), 64'd0);
    checkOutput("rst_ddr_addr", 64'(ddr_addr), 64'd0);
    @(negedge clk);

    // Initial load of page 0, then the whole page read back in order
    pushPage(0);
    rst = 1'b1;
    waitState(4'd3, 2000, "load0_done");
    checkOutput("load0_times", 64'(load_times), 64'd1);
    checkOutput("load0_reqs_left", 64'(exp_req.size()), 64'd0);
    applyStimulus(16'h8000, 1'b0, 64'd0);
    for (int i = 0; i < 64; i++) applyStimulus(16'(i), 1'b1, 64'(i));

    // Sequential boundary miss into page 1, loaded under backpressure and return gaps
    pushPage(1);
    bp_mode = 1'b1;
    applyStimulus(16'd64, 1'b0, 64'd0);
    addr_ins = 16'h8000;
    waitState(4'd2, 5, "load1_started");
    waitState(4'd3, 2000, "load1_done");
    bp_mode = 1'b0;
    checkOutput("load1_times", 64'(load_times), 64'd2);
    checkOutput("load1_reqs_left", 64'(exp_req.size()), 64'd0);
    for (int i = 64; i < 128; i++) applyStimulus(16'(i), 1'b1, 64'(i));

    // Jump pending holds the page, then a jump target in page 0 reloads it
    repeat (5) applyStimulus(16'h8000, 1'b0, 64'd0);
    checkOutput("jump_state", 64'(st_cur_ins_cache), 64'd3);
    checkOutput("jump_load_times", 64'(load_times), 64'd2);
    pushPage(0);
    applyStimulus(16'd10, 1'b0, 64'd0);
    addr_ins = 16'h8000;
    waitState(4'd3, 2000, "jump_reload_done");
    checkOutput("jump_reload_times", 64'(load_times), 64'd1);
    checkOutput("jump_reqs_left", 64'(exp_req.size()), 64'd0);
    applyStimulus(16'd10, 1'b1, 64'd10);
    applyStimulus(16'd11, 1'b1, 64'd11);
    applyStimulus(16'd63, 1'b1, 64'd63);

    // Program end: no hit, no reload
    repeat (20) applyStimulus(16'd128, 1'b0, 64'd0);
    checkOutput("end_state", 64'(st_cur_ins_cache), 64'd3);
    checkOutput("end_ins_valid", 64'(ins_valid), 64'd0);

    // Reset in the middle of a page-1 load after 30 returns
    pushPage(1);
    ret_count = 0;
    applyStimulus(16'd64, 1'b0, 64'd0);
    addr_ins = 16'h8000;
    n = 0;
    while (ret_count < 30 && n < 1000) begin
      @(negedge clk);
      n++;
    end
    checkOutput("midload_returns_reached", 64'(ret_count >= 30), 64'd1);
    #2 rst = 1'b0;
    #1;
    checkOutput("midload_rst_state", 64'(st_cur_ins_cache), 64'd1);
    checkOutput("midload_rst_load_times", 64'(load_times), 64'd0);
    checkOutput("midload_rst_rd_en", 64'(ddr_rd_en), 64'd0);
    exp_req.delete();
    late_strobe = 1'b1;
    repeat (2) @(negedge clk);
    pushPage(0);
    rst = 1'b1;
    #1 late_strobe = 1'b0;
    waitState(4'd3, 2000, "post_rst_load_done");
    checkOutput("post_rst_load_times", 64'(load_times), 64'd1);
    checkOutput("post_rst_reqs_left", 64'(exp_req.size()), 64'd0);
    for (int i = 0; i < 64; i++) applyStimulus(16'(i), 1'b1, 64'(i));
    applyStimulus(16'h8000, 1'b0, 64'd0);
    @(negedge clk);
    #1;
    checkOutput("ins_queue_drained", 64'(exp_ins.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
